// File: rtl/pool2_pkg.sv
// Shared types and derived-size helpers for the Pool2 control unit.
package pool2_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STREAM     = 2'd1,
    NEXT_GROUP = 2'd2,
    DRAIN      = 2'd3
  } state_e;

  function automatic int unsigned ofm_size(input int unsigned ifm_size);
    return (ifm_size - 2) / 2 + 1;
  endfunction

  function automatic int unsigned num_groups(input int unsigned depth, input int unsigned units);
    return (depth + units - 1) / units;
  endfunction

  // A unit is live when its map index exists; only the last group can be partial.
  function automatic logic unit_active(input int unsigned group, input int unsigned unit,
                                       input int unsigned units, input int unsigned depth);
    return (group * units + unit) < depth;
  endfunction

endpackage

// File: rtl/pool2_delay_line.sv
// Reset-able shift register; MSB of the payload is treated as the valid flag.
module pool2_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             inflight_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q_o        = d_i;
      assign inflight_o = 1'b0;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];

      // Valid bits still travelling, excluding the one at the output.
      always_comb begin
        inflight_o = 1'b0;
        for (int i = 0; i < int'(DEPTH) - 1; i++) inflight_o = inflight_o | stage_q[i][WIDTH-1];
      end
    end
  endgenerate

endmodule

// File: rtl/pool2_ctrl.sv
// Pool2 control: IFM row-pair address streaming, pool/FIFO strobes and OFM writes.
// Optional POOL2_STALL_EN adds a stall input that freezes streaming.
module pool2_ctrl
  import pool2_pkg::*;
#(
  parameter int unsigned IFM_SIZE              = 14,
  parameter int unsigned IFM_DEPTH             = 3,
  parameter int unsigned NUMBER_OF_UNITS       = 3,
  parameter int unsigned POOL_LATENCY          = 1,
  parameter int unsigned IFM_SIZE_NEXT         = ofm_size(IFM_SIZE),
  parameter int unsigned ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int unsigned ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
  parameter int unsigned NUM_GROUPS            = num_groups(IFM_DEPTH, NUMBER_OF_UNITS),
  parameter int unsigned GROUP_WIDTH           = $clog2(NUM_GROUPS) + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
`ifdef POOL2_STALL_EN
  input  logic                             stall,
`endif
  output logic                             ifm_rd_en,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_addr_A,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_addr_B,
  output logic [GROUP_WIDTH-1:0]           group_index,
  output logic                             fifo_enable,
  output logic                             pool_enable,
  output logic                             ofm_we,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_addr,
  output logic [NUMBER_OF_UNITS-1:0]       ofm_unit_mask,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned AW         = ADDRESS_SIZE_IFM;
  localparam int unsigned OW         = ADDRESS_SIZE_NEXT_IFM;
  localparam int unsigned GW         = GROUP_WIDTH;
  localparam int unsigned U          = NUMBER_OF_UNITS;
  localparam int unsigned CW         = $clog2(IFM_SIZE) + 1;
  localparam int unsigned RW         = $clog2(IFM_SIZE_NEXT) + 1;
  localparam int unsigned OFM_PIXELS = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
  localparam int unsigned MEM_W      = 2 + GW + U;
  localparam int unsigned LAT_W      = 1 + GW + U;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   rp_q, rp_d;
  logic [AW-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [GW-1:0]   group_q, group_d;
  logic [OW-1:0]   ofm_addr_q, ofm_addr_d;
  logic            done_q, done_d, busy_q, busy_d;

  logic            advance_c, last_col_c, last_pair_c, pool_req_c, inflight_c;
  logic            mem_inflight_c, lat_inflight_c;
  logic [U-1:0]    mask_c, mem_mask_c;
  logic [GW-1:0]   mem_group_c;
  logic [MEM_W-1:0] mem_q_c;
  logic [LAT_W-1:0] lat_q_c;

`ifdef POOL2_STALL_EN
  assign advance_c = (state_q == STREAM) && !stall;
`else
  assign advance_c = (state_q == STREAM);
`endif

  assign last_col_c  = (col_q == CW'(IFM_SIZE - 1));
  assign last_pair_c = (rp_q == RW'(IFM_SIZE_NEXT - 1));
  // Odd columns close a 2x2 window; a trailing odd-size column is never pooled.
  assign pool_req_c  = advance_c && col_q[0] && (col_q < CW'(2 * IFM_SIZE_NEXT));

  always_comb begin
    mask_c = '0;
    for (int unsigned u = 0; u < U; u++)
      mask_c[u] = unit_active(32'(group_q), u, U, IFM_DEPTH);
  end

  // Memory read stage carries the FIFO strobe alongside the pool payload.
  pool2_delay_line #(.WIDTH(MEM_W), .DEPTH(1)) u_mem_stage (
    .clk       (clk),
    .reset     (reset),
    .d_i       ({pool_req_c, advance_c, group_q, mask_c}),
    .q_o       (mem_q_c),
    .inflight_o(mem_inflight_c)
  );

  assign {pool_enable, fifo_enable, mem_group_c, mem_mask_c} = mem_q_c;

  pool2_delay_line #(.WIDTH(LAT_W), .DEPTH(POOL_LATENCY)) u_lat_stage (
    .clk       (clk),
    .reset     (reset),
    .d_i       ({pool_enable, mem_group_c, mem_mask_c}),
    .q_o       (lat_q_c),
    .inflight_o(lat_inflight_c)
  );

  assign {ofm_we, group_index, ofm_unit_mask} = lat_q_c;

  // Any pool strobe that has not yet reached ofm_we.
  assign inflight_c = pool_req_c | mem_inflight_c | lat_inflight_c |
                      ((POOL_LATENCY != 0) && pool_enable);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    rp_d     = rp_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    group_d  = group_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = STREAM;
          col_d    = '0;
          rp_d     = '0;
          addr_a_d = '0;
          addr_b_d = AW'(IFM_SIZE);
          group_d  = '0;
        end
      end
      STREAM: begin
        if (advance_c) begin
          if (!last_col_c) begin
            col_d    = col_q + CW'(1);
            addr_a_d = addr_a_q + AW'(1);
            addr_b_d = addr_b_q + AW'(1);
          end else if (!last_pair_c) begin
            col_d    = '0;
            rp_d     = rp_q + RW'(1);
            addr_a_d = addr_a_q + AW'(IFM_SIZE + 1);
            addr_b_d = addr_b_q + AW'(IFM_SIZE + 1);
          end else begin
            col_d    = '0;
            rp_d     = '0;
            addr_a_d = '0;
            addr_b_d = AW'(IFM_SIZE);
            state_d  = NEXT_GROUP;
          end
        end
      end
      NEXT_GROUP: begin
        if (group_q < GW'(NUM_GROUPS - 1)) begin
          group_d = group_q + GW'(1);
          state_d = STREAM;
        end else if (inflight_c) begin
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (!inflight_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  // OFM address wraps after a full map, which lines up with each group boundary.
  always_comb begin
    ofm_addr_d = ofm_addr_q;
    if (state_q == IDLE && start)
      ofm_addr_d = '0;
    else if (ofm_we)
      ofm_addr_d = (ofm_addr_q == OW'(OFM_PIXELS - 1)) ? '0 : ofm_addr_q + OW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      rp_q       <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      group_q    <= '0;
      ofm_addr_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      rp_q       <= rp_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      group_q    <= group_d;
      ofm_addr_q <= ofm_addr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign ifm_rd_en  = advance_c;
  assign ifm_addr_A = addr_a_q;
  assign ifm_addr_B = addr_b_q;
  assign ofm_addr   = ofm_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pool2_ctrl.sv
// Scoreboard bench for pool2_ctrl: default 14x14x3 instance plus a 5x5x5 two-group instance.
module tb_pool2_ctrl;

  typedef struct {int a; int b;} rd_t;
  typedef struct {int grp; int mask; int addr;} wr_t;

  logic clk = 1'b0;
  logic reset, start1, start2;
`ifdef POOL2_STALL_EN
  logic stall = 1'b0;
`endif
  always #5 clk = ~clk;

  logic       rd1, fifo1, pool1, we1, busy1, done1;
  logic [7:0] a1, b1;
  logic [0:0] grp1;
  logic [5:0] oaddr1;
  logic [2:0] mask1;

  logic       rd2, fifo2, pool2, we2, busy2, done2;
  logic [4:0] a2, b2;
  logic [1:0] grp2;
  logic [1:0] oaddr2;
  logic [2:0] mask2;

  pool2_ctrl u_dut1 (
    .clk(clk), .reset(reset), .start(start1),
`ifdef POOL2_STALL_EN
    .stall(stall),
`endif
    .ifm_rd_en(rd1), .ifm_addr_A(a1), .ifm_addr_B(b1), .group_index(grp1),
    .fifo_enable(fifo1), .pool_enable(pool1), .ofm_we(we1), .ofm_addr(oaddr1),
    .ofm_unit_mask(mask1), .busy(busy1), .done(done1)
  );

  pool2_ctrl #(.IFM_SIZE(5), .IFM_DEPTH(5), .NUMBER_OF_UNITS(3), .POOL_LATENCY(1)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2),
`ifdef POOL2_STALL_EN
    .stall(1'b0),
`endif
    .ifm_rd_en(rd2), .ifm_addr_A(a2), .ifm_addr_B(b2), .group_index(grp2),
    .fifo_enable(fifo2), .pool_enable(pool2), .ofm_we(we2), .ofm_addr(oaddr2),
    .ofm_unit_mask(mask2), .busy(busy2), .done(done2)
  );

  int checks = 0, failures = 0;
  int cyc = 0, t0_1 = 0, t0_2 = 0;
  rd_t exp_rd1[$], exp_rd2[$];
  wr_t exp_wr1[$], exp_wr2[$];

  int  first_rd1 = -1, last_rd1 = -1, last_we1 = -1, done_rel1 = -1, done_cnt1 = 0, pool_cnt1 = 0;
  int  last_we2 = -1, done_rel2 = -1, done_cnt2 = 0, pool_cnt2 = 0;
  bit  seen_rd1 = 1'b0, prev_rd1 = 1'b0, prev_rd2 = 1'b0;
  int  prev_a1 = 0, prev_a2 = 0;
  rd_t e1, e2;
  wr_t w1, w2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push1();
    for (int rp = 0; rp < 7; rp++)
      for (int c = 0; c < 14; c++) exp_rd1.push_back('{a: 28*rp + c, b: 28*rp + c + 14});
    for (int k = 0; k < 49; k++) exp_wr1.push_back('{grp: 0, mask: 7, addr: k});
  endtask

  task automatic push2();
    for (int g = 0; g < 2; g++) begin
      for (int rp = 0; rp < 2; rp++)
        for (int c = 0; c < 5; c++) exp_rd2.push_back('{a: 10*rp + c, b: 10*rp + c + 5});
      for (int k = 0; k < 4; k++) exp_wr2.push_back('{grp: g, mask: (g == 0) ? 7 : 3, addr: k});
    end
  endtask

  // Monitor for the default instance.
  always @(negedge clk) begin
    if (reset) begin
      prev_rd1 = 1'b0;
    end else begin
      if (start1 && !busy1) begin seen_rd1 = 1'b0; pool_cnt1 = 0; end
      if (rd1) begin
        if (!seen_rd1) begin seen_rd1 = 1'b1; first_rd1 = cyc - t0_1; end
        last_rd1 = cyc - t0_1;
        if (exp_rd1.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd1_unexpected: got read at %0d expected none", a1);
        end else begin
          e1 = exp_rd1.pop_front();
          chk("rd1_addr_A", a1, e1.a);
          chk("rd1_addr_B", b1, e1.b);
        end
      end
      if (fifo1 || prev_rd1) chk("fifo1_follows_rd", fifo1, prev_rd1);
      if (pool1) begin
        pool_cnt1++;
        chk("pool1_src_odd_col", {prev_rd1, (prev_a1 % 14) % 2 == 1}, 2'b11);
      end
      prev_rd1 = rd1;
      prev_a1  = a1;
      if (we1) begin
        last_we1 = cyc - t0_1;
        if (exp_wr1.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr1_unexpected: got write addr %0d expected none", oaddr1);
        end else begin
          w1 = exp_wr1.pop_front();
          chk("wr1_group", grp1, w1.grp);
          chk("wr1_mask", mask1, w1.mask);
          chk("wr1_addr", oaddr1, w1.addr);
        end
      end
      if (done1) begin
        done_cnt1++;
        done_rel1 = cyc - t0_1;
        chk("busy1_low_with_done", busy1, 0);
      end
`ifdef POOL2_STALL_EN
      if (stall) chk("rd1_during_stall", rd1, 0);
`endif
    end
  end

  // Monitor for the 5x5, two-group instance.
  always @(negedge clk) begin
    if (reset) begin
      prev_rd2 = 1'b0;
    end else begin
      if (start2 && !busy2) pool_cnt2 = 0;
      if (rd2) begin
        if (exp_rd2.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd2_unexpected: got read at %0d expected none", a2);
        end else begin
          e2 = exp_rd2.pop_front();
          chk("rd2_addr_A", a2, e2.a);
          chk("rd2_addr_B", b2, e2.b);
        end
      end
      if (fifo2 || prev_rd2) chk("fifo2_follows_rd", fifo2, prev_rd2);
      if (pool2) begin
        pool_cnt2++;
        chk("pool2_src_col_1_or_3", {prev_rd2, (prev_a2 % 5 == 1) || (prev_a2 % 5 == 3)}, 2'b11);
      end
      prev_rd2 = rd2;
      prev_a2  = a2;
      if (we2) begin
        last_we2 = cyc - t0_2;
        if (exp_wr2.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr2_unexpected: got write addr %0d expected none", oaddr2);
        end else begin
          w2 = exp_wr2.pop_front();
          chk("wr2_group", grp2, w2.grp);
          chk("wr2_mask", mask2, w2.mask);
          chk("wr2_addr", oaddr2, w2.addr);
        end
      end
      if (done2) begin
        done_cnt2++;
        done_rel2 = cyc - t0_2;
      end
    end
  end

  task automatic pulse_start(input bit both);
    @(posedge clk); #1;
    start1 = 1'b1; t0_1 = cyc;
    if (both) begin start2 = 1'b1; t0_2 = cyc; end
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    chk("busy1_cycle1", busy1, 1);
  endtask

  task automatic wait_rel(input int k);
    while ((cyc - t0_1) < k) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done1(input int exp_done, input int exp_last_we);
    int d0;
    d0 = done_cnt1;
    for (int i = 0; i < 400 && done_cnt1 == d0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("done1_pulses", done_cnt1 - d0, 1);
    chk("done1_cycle", done_rel1, exp_done);
    chk("last_we1_cycle", last_we1, exp_last_we);
    chk("first_rd1_cycle", first_rd1, 1);
    chk("last_rd1_cycle", last_rd1, exp_done - 3);
    chk("pool1_count", pool_cnt1, 49);
    chk("rd1_left", exp_rd1.size(), 0);
    chk("wr1_left", exp_wr1.size(), 0);
    chk("busy1_after_done", busy1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_dut1", {rd1, a1, b1, grp1, fifo1, pool1, we1, oaddr1, mask1, busy1, done1}, 0);
    chk("reset_outputs_dut2", {rd2, a2, b2, grp2, fifo2, pool2, we2, oaddr2, mask2, busy2, done2}, 0);
    reset = 1'b0;

    // Full default run alongside the two-group partial-mask run.
    push1(); push2();
    pulse_start(1'b1);
    wait_done1(101, 100);
    chk("done2_pulses", done_cnt2, 1);
    chk("done2_cycle", done_rel2, 23);
    chk("last_we2_cycle", last_we2, 22);
    chk("pool2_count", pool_cnt2, 8);
    chk("rd2_left", exp_rd2.size(), 0);
    chk("wr2_left", exp_wr2.size(), 0);

    // Re-pulsed start while busy must be ignored.
    push1();
    pulse_start(1'b0);
    wait_rel(20);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_done1(101, 100);

    // Asynchronous reset mid-run.
    push1();
    pulse_start(1'b0);
    wait_rel(40);
    #1 reset = 1'b1;
    #1;
    chk("midrun_reset_outputs", {rd1, a1, b1, grp1, fifo1, pool1, we1, oaddr1, mask1, busy1, done1}, 0);
    exp_rd1.delete();
    exp_wr1.delete();
    d0 = done_cnt1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (150) @(posedge clk);
    chk("no_done_after_reset", done_cnt1 - d0, 0);
    push1();
    pulse_start(1'b0);
    wait_done1(101, 100);

`ifdef POOL2_STALL_EN
    // Stall for cycles 10..14 freezes streaming and delays done by 5.
    push1();
    pulse_start(1'b0);
    wait_rel(10);
    stall = 1'b1;
    wait_rel(15);
    stall = 1'b0;
    wait_done1(106, 105);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool2_ctrl.md
Name: pool2_ctrl

Overview:
- Control unit for the Pool2 datapath, which holds NUMBER_OF_UNITS parallel 2x2/stride-2 max-pool units.
- Reads input feature maps (IFMs) from IFM memory and generates both IFM read addresses (row pair A/B, one pixel column per cycle) and the datapath's fifo_enable/pool_enable.
- Generates output feature map (OFM) write address/enable.
- Sequences all IFM_DEPTH maps in groups of NUMBER_OF_UNITS; sits between the top-level layer FSM and the IFM/OFM memories.

Parameters:
- IFM_SIZE, 14, IFM width/height in pixels.
- IFM_DEPTH, 3, number of input maps.
- NUMBER_OF_UNITS, 3, pool units operating in parallel.
- POOL_LATENCY, 1, cycles from pool_enable to valid unit_data_out.
- IFM_SIZE_NEXT, (IFM_SIZE-2)/2+1, OFM width/height.
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), IFM address width.
- ADDRESS_SIZE_NEXT_IFM, $clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT), OFM address width.
- NUM_GROUPS, ceil(IFM_DEPTH/NUMBER_OF_UNITS), passes per layer.
- GROUP_WIDTH, $clog2(NUM_GROUPS)+1, group index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, begin layer
- ifm_rd_en  out  1  IFM memory read strobe
- ifm_addr_A  out  ADDRESS_SIZE_IFM  upper-row pixel address
- ifm_addr_B  out  ADDRESS_SIZE_IFM  lower-row pixel address
- group_index  out  GROUP_WIDTH  current map group (selects IFM bank base)
- fifo_enable  out  1  datapath FIFO shift, valid data present
- pool_enable  out  1  datapath pool compute strobe
- ofm_we  out  1  OFM write enable
- ofm_addr  out  ADDRESS_SIZE_NEXT_IFM  OFM write address
- ofm_unit_mask  out  NUMBER_OF_UNITS  per-unit write qualifier for partial last group
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse, layer complete

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; all counters cleared. Reset mid-operation aborts immediately and no done pulse follows.
- States and transitions:
  - IDLE: on start go to STREAM; group=0, rp=0, c=0.
  - STREAM: ifm_rd_en=1 every cycle. After c=IFM_SIZE-1 with rp=IFM_SIZE_NEXT-1, go to NEXT_GROUP.
  - NEXT_GROUP: 1 cycle. If group<NUM_GROUPS-1, increment group, clear rp/c, go to STREAM; else go to DRAIN.
  - DRAIN: wait for in-flight pipeline to empty, pulse done, go to IDLE.
- start while busy is ignored. busy=1 in every state except IDLE.
- Addressing:
  - ifm_addr_A = 2*rp*IFM_SIZE + c; ifm_addr_B = ifm_addr_A + IFM_SIZE.
  - Generated incrementally (no multiplier): +1 per column; +IFM_SIZE+1 at end of row pair.
  - c wraps 0..IFM_SIZE-1; rp wraps 0..IFM_SIZE_NEXT-1.
- Pipeline:
  - Memory read latency is 1 cycle.
  - fifo_enable = ifm_rd_en delayed 1.
  - pool_enable = (ifm_rd_en && c odd && c<2*IFM_SIZE_NEXT) delayed 1. For odd IFM_SIZE the trailing column is read but never pooled.
  - ofm_we = pool_enable delayed POOL_LATENCY.
- OFM addressing:
  - ofm_addr is 0 at group start and increments after each ofm_we, up to IFM_SIZE_NEXT^2-1.
  - ofm_addr resets to 0 at each group boundary, aligned with the first ofm_we of the new group.
- group_index and ofm_unit_mask travel down the pipeline with ofm_we.
  - ofm_unit_mask is all ones, except in the last group, where bit u=1 iff group*NUMBER_OF_UNITS+u < IFM_DEPTH.
- done asserts 1 cycle after the final ofm_we. busy falls in the same cycle as done.

Optional Feature:
- Macro: POOL2_STALL_EN.
- Enabled: adds input stall (1 bit). While stall=1 in STREAM:
  - ifm_rd_en=0 and rp/c/addresses hold.
  - Already-issued reads still complete, so fifo_enable/pool_enable/ofm_we may continue for up to 1+POOL_LATENCY cycles.
  - stall in other states has no effect.
- Disabled: no stall port; streaming is unconditional.

Decomposition:
- Package pool2_pkg: FSM state enum (IDLE, STREAM, NEXT_GROUP, DRAIN) and the derived-size functions/constants (IFM_SIZE_NEXT, NUM_GROUPS, unit-mask computation).
- One sub-module, pool2_delay_line: parameterised-width/depth shift register carrying {pool_enable, group_index, mask}. It implements both the 1-cycle memory stage and the POOL_LATENCY stage.

Test Plan:
- Defaults, start pulse at cycle 0 ->
  - ifm_rd_en cycles 1..98; first address pairs (0,14), (1,15); row pair 1 begins (28,42); last pair (181,195).
  - 49 ofm_we with ofm_addr 0..48; last ofm_we at cycle 100; done at cycle 101.
- IFM_DEPTH=5, NUMBER_OF_UNITS=3 ->
  - two groups; group_index 0 then 1; ofm_unit_mask 3'b111 then 3'b011.
  - 98 total ofm_we; ofm_addr restarts at 0 for group 1.
- Reset asserted at cycle 40 of a run -> all outputs 0 asynchronously; no done pulse; a new start runs a full, correct sequence.
- start re-pulsed at cycle 20 while busy -> ignored; address sequence and done timing are identical to the first scenario.
- IFM_SIZE=5 -> IFM_SIZE_NEXT=2; pool_enable only for c=1,3; column 4 is read but not pooled; 4 ofm_we per group.
- POOL2_STALL_EN, stall high for cycles 10..14 ->
  - no reads in cycles 10..14; addresses frozen at their cycle-9 value+1.
  - ofm_we count still 49; done delayed by exactly 5 cycles.
